sbox_share_arbiter: RTL and testbench

- Shares one 32-bit S-box bank (four byte S-boxes, combinational) between two requesters.
- Requester ST is the round datapath: full 128-bit SubBytes, processed one word per cycle over 4 cycles.
- Requester KW is key expansion: a single 32-bit SubWord.
- Sits between the round controller, the key-schedule logic and the shared S-box instance. Two 128-bit-wide S-box banks are replaced by one 32-bit bank.

---
 rtl/sbox_share_arbiter.sv | 125 ++++++++++++
 tb/tb_sbox_share_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_arbiter.sv
// Time-shares one 32-bit S-box bank between the round datapath (128-bit SubBytes,
// one word per cycle) and key expansion (single 32-bit SubWord).
module sbox_share_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req,
    input  logic [127:0] st_in,
    output logic         st_ack,
    output logic [127:0] st_out,
    input  logic         kw_req,
    input  logic [31:0]  kw_in,
    output logic         kw_ack,
    output logic [31:0]  kw_out,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KW_RUN = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    // Element 3 holds [127:96], i.e. word0 of the state.
    logic [3:0][31:0]  st_buf_q, st_buf_d;
    logic [3:0][31:0]  st_out_q, st_out_d;
    logic [31:0]       kw_buf_q, kw_buf_d;
    logic [31:0]       kw_out_q, kw_out_d;
    logic              st_ack_q, st_ack_d;
    logic              kw_ack_q, kw_ack_d;
    logic              last_kw_q, last_kw_d;

    logic              grant_kw;
    logic              grant_st;
    logic [1:0]        wsel;

    // KW wins when ST is not asking, when priority is fixed, or when it is KW's turn.
    assign grant_kw = kw_req & (~st_req | ~RR_EN | ~last_kw_q);
    assign grant_st = st_req & ~grant_kw;
    assign wsel     = ~cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        st_buf_d  = st_buf_q;
        st_out_d  = st_out_q;
        kw_buf_d  = kw_buf_q;
        kw_out_d  = kw_out_q;
        last_kw_d = last_kw_q;
        st_ack_d  = 1'b0;
        kw_ack_d  = 1'b0;
        sb_in     = 32'h0;

        unique case (state_q)
            IDLE: begin
                if (grant_kw) begin
                    kw_buf_d  = kw_in;
                    last_kw_d = 1'b1;
                    state_d   = KW_RUN;
                end else if (grant_st) begin
                    st_buf_d  = st_in;
                    cnt_d     = 2'd0;
                    last_kw_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                sb_in          = st_buf_q[wsel];
                st_out_d[wsel] = sb_out;
                cnt_d          = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    st_ack_d = 1'b1;
                    state_d  = DONE;
                end
            end
            KW_RUN: begin
                sb_in    = kw_buf_q;
                kw_out_d = sb_out;
                kw_ack_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            st_buf_q  <= '0;
            st_out_q  <= '0;
            kw_buf_q  <= '0;
            kw_out_q  <= '0;
            st_ack_q  <= 1'b0;
            kw_ack_q  <= 1'b0;
            last_kw_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            st_buf_q  <= st_buf_d;
            st_out_q  <= st_out_d;
            kw_buf_q  <= kw_buf_d;
            kw_out_q  <= kw_out_d;
            st_ack_q  <= st_ack_d;
            kw_ack_q  <= kw_ack_d;
            last_kw_q <= last_kw_d;
        end
    end

    assign st_ack = st_ack_q;
    assign kw_ack = kw_ack_q;
    assign st_out = st_out_q;
    assign kw_out = kw_out_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Bench for sbox_share_arbiter: one round-robin and one fixed-priority instance,
// each fed by an AES S-box model, checked against a transaction-level model.
module tb_sbox_share_arbiter;

    localparam logic [127:0] V1 = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
    localparam logic [127:0] E1 = 128'hD42711AEE0BF98F1B8B45DE51E415230;
    localparam logic [127:0] EZ = 128'h63636363636363636363636363636363;
    localparam logic [31:0]  KI = 32'hCF4F3C09;
    localparam logic [31:0]  KO = 32'h8A84EB01;

    logic [7:0] sbox_t [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] subst128(input logic [127:0] v);
        return {subw(v[127:96]), subw(v[95:64]), subw(v[63:32]), subw(v[31:0])};
    endfunction

    function automatic logic [31:0] wordk(input logic [127:0] v, input int k);
        logic [127:0] t;
        t = v << (32 * k);
        return t[127:96];
    endfunction

    logic         clk;
    logic         rst;
    logic         st_req_s [2];
    logic [127:0] st_in_s  [2];
    logic         kw_req_s [2];
    logic [31:0]  kw_in_s  [2];
    logic         st_ack_w [2];
    logic [127:0] st_out_w [2];
    logic         kw_ack_w [2];
    logic [31:0]  kw_out_w [2];
    logic [31:0]  sb_in_w  [2];
    logic [31:0]  sb_out_w [2];
    logic         busy_w   [2];

    assign sb_out_w[0] = subw(sb_in_w[0]);
    assign sb_out_w[1] = subw(sb_in_w[1]);

    sbox_share_arbiter #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .st_req(st_req_s[0]), .st_in(st_in_s[0]), .st_ack(st_ack_w[0]), .st_out(st_out_w[0]),
        .kw_req(kw_req_s[0]), .kw_in(kw_in_s[0]), .kw_ack(kw_ack_w[0]), .kw_out(kw_out_w[0]),
        .sb_in(sb_in_w[0]), .sb_out(sb_out_w[0]), .busy(busy_w[0])
    );

    sbox_share_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .st_req(st_req_s[1]), .st_in(st_in_s[1]), .st_ack(st_ack_w[1]), .st_out(st_out_w[1]),
        .kw_req(kw_req_s[1]), .kw_in(kw_in_s[1]), .kw_ack(kw_ack_w[1]), .kw_out(kw_out_w[1]),
        .sb_in(sb_in_w[1]), .sb_out(sb_out_w[1]), .busy(busy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] at %0t: got %h want %h", nm, idx, $time, act, exp);
        end
    endtask

    // Transaction model: owner 0 = none, 1 = ST, 2 = KW; age = cycles since accept edge.
    // ST owns the bank for 5 cycles (4 words + ack), KW for 2 (1 word + ack).
    int           m_own  [2] = '{0, 0};
    int           m_age  [2] = '{0, 0};
    bit           m_last_kw [2] = '{1'b0, 1'b0};
    bit           m_rr   [2] = '{1'b1, 1'b0};
    logic [127:0] m_st_cap [2];
    logic [127:0] m_st_out [2] = '{128'h0, 128'h0};
    logic [31:0]  m_kw_cap [2];
    logic [31:0]  m_kw_out [2] = '{32'h0, 32'h0};

    initial forever begin
        @(posedge clk or posedge rst);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_own[i] = 0; m_age[i] = 0; m_last_kw[i] = 1'b0;
                m_st_out[i] = '0; m_kw_out[i] = '0;
            end else if (m_own[i] == 0) begin
                if (kw_req_s[i] && (!st_req_s[i] || !m_rr[i] || !m_last_kw[i])) begin
                    m_own[i] = 2; m_age[i] = 1; m_kw_cap[i] = kw_in_s[i]; m_last_kw[i] = 1'b1;
                end else if (st_req_s[i]) begin
                    m_own[i] = 1; m_age[i] = 1; m_st_cap[i] = st_in_s[i]; m_last_kw[i] = 1'b0;
                end
            end else begin
                if (m_own[i] == 1 && m_age[i] == 4) m_st_out[i] = subst128(m_st_cap[i]);
                if (m_own[i] == 2 && m_age[i] == 1) m_kw_out[i] = subw(m_kw_cap[i]);
                if (m_age[i] == ((m_own[i] == 1) ? 5 : 2)) begin
                    m_own[i] = 0; m_age[i] = 0;
                end else begin
                    m_age[i] = m_age[i] + 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] e_sb;
            bit st_run;
            st_run = (m_own[i] == 1) && (m_age[i] <= 4);
            e_sb = 32'h0;
            if (st_run) e_sb = wordk(m_st_cap[i], m_age[i] - 1);
            else if (m_own[i] == 2 && m_age[i] == 1) e_sb = m_kw_cap[i];
            chk("busy", i, 128'(busy_w[i]), 128'(m_own[i] != 0));
            chk("st_ack", i, 128'(st_ack_w[i]), 128'(m_own[i] == 1 && m_age[i] == 5));
            chk("kw_ack", i, 128'(kw_ack_w[i]), 128'(m_own[i] == 2 && m_age[i] == 2));
            chk("sb_in", i, 128'(sb_in_w[i]), 128'(e_sb));
            chk("kw_out", i, 128'(kw_out_w[i]), 128'(m_kw_out[i]));
            if (!st_run) chk("st_out", i, st_out_w[i], m_st_out[i]);
        end
    end

    // Ack cycle numbers are counted in negedges from the request raise: n=1 is the
    // IDLE cycle before the accept edge, so n = cycles-after-accept + 1.
    int          st_hit [4];
    int          kw_hit [4];
    logic [31:0] sb_log [16];

    task automatic serve(input int i, input int nst, input int nkw);
        int sd, kd;
        logic sa, ka;
        sd = 0; kd = 0;
        for (int k = 0; k < 4; k++) begin st_hit[k] = 0; kw_hit[k] = 0; end
        for (int k = 0; k < 16; k++) sb_log[k] = '0;
        st_req_s[i] = (nst > 0);
        kw_req_s[i] = (nkw > 0);
        for (int n = 1; n <= 80 && (sd < nst || kd < nkw); n++) begin
            @(negedge clk);
            sa = st_ack_w[i];
            ka = kw_ack_w[i];
            if (n < 16) sb_log[n] = sb_in_w[i];
            if (sa) begin if (sd < 4) st_hit[sd] = n; sd++; end
            if (ka) begin if (kd < 4) kw_hit[kd] = n; kd++; end
            @(posedge clk); #1;
            if (sa && sd >= nst) st_req_s[i] = 1'b0;
            if (ka && kd >= nkw) kw_req_s[i] = 1'b0;
        end
        st_req_s[i] = 1'b0;
        kw_req_s[i] = 1'b0;
        chk("serve_done", i, 128'(sd == nst && kd == nkw), 128'(1));
    endtask

    task automatic pulse_rst();
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st_req_s[i] = 1'b0; kw_req_s[i] = 1'b0; st_in_s[i] = '0; kw_in_s[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_st_out", 0, st_out_w[0], 128'h0);
        chk("rst_busy", 0, 128'(busy_w[0]), 128'(0));

        // Single ST block: 5-cycle latency, word order on the bank
        st_in_s[0] = V1;
        serve(0, 1, 0);
        chk("t1_lat", 0, 128'(st_hit[0]), 128'(6));
        chk("t1_out", 0, st_out_w[0], E1);
        chk("t1_sb0", 0, 128'(sb_log[2]), 128'(32'h193DE3BE));
        chk("t1_sb1", 0, 128'(sb_log[3]), 128'(32'hA0F4E22B));
        chk("t1_sb2", 0, 128'(sb_log[4]), 128'(32'h9AC68D2A));
        chk("t1_sb3", 0, 128'(sb_log[5]), 128'(32'hE9F84808));

        // Single KW word: 2-cycle latency, st_out untouched
        kw_in_s[0] = KI;
        serve(0, 0, 1);
        chk("t2_lat", 0, 128'(kw_hit[0]), 128'(3));
        chk("t2_out", 0, 128'(kw_out_w[0]), 128'(KO));
        chk("t2_st_keep", 0, st_out_w[0], E1);

        // Round-robin ties: KW first after reset, then ST wins the repeated tie
        pulse_rst();
        st_in_s[0] = V1; kw_in_s[0] = KI;
        serve(0, 1, 2);
        chk("rr_kw1", 0, 128'(kw_hit[0]), 128'(3));
        chk("rr_st", 0, 128'(st_hit[0]), 128'(9));
        chk("rr_kw2", 0, 128'(kw_hit[1]), 128'(12));
        chk("rr_st_out", 0, st_out_w[0], E1);

        // Fixed priority: KW keeps winning while it holds req
        st_in_s[1] = '0; kw_in_s[1] = KI;
        serve(1, 1, 3);
        chk("fp_kw1", 1, 128'(kw_hit[0]), 128'(3));
        chk("fp_kw2", 1, 128'(kw_hit[1]), 128'(6));
        chk("fp_kw3", 1, 128'(kw_hit[2]), 128'(9));
        chk("fp_st", 1, 128'(st_hit[0]), 128'(15));
        chk("fp_st_out", 1, st_out_w[1], EZ);
        chk("fp_kw_out", 1, 128'(kw_out_w[1]), 128'(KO));

        // Reset in the middle of an ST block (cnt = 2)
        st_in_s[0] = V1; st_req_s[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_sb2", 0, 128'(sb_in_w[0]), 128'(32'h9AC68D2A));
        #2 rst = 1'b1;
        #1;
        chk("mid_busy", 0, 128'(busy_w[0]), 128'(0));
        chk("mid_st_out", 0, st_out_w[0], 128'h0);
        chk("mid_kw_out", 0, 128'(kw_out_w[0]), 128'(0));
        chk("mid_ack", 0, 128'(st_ack_w[0]), 128'(0));
        st_req_s[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        st_in_s[0] = '0;
        serve(0, 1, 0);
        chk("zero_lat", 0, 128'(st_hit[0]), 128'(6));
        chk("zero_out", 0, st_out_w[0], EZ);

        // Input changed and req dropped right after grant
        st_in_s[0] = V1; st_req_s[0] = 1'b1;
        @(posedge clk); #1;
        st_in_s[0] = ~V1; st_req_s[0] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(negedge clk);
            if (st_ack_w[0]) lat = n;
        end
        chk("drop_lat", 0, 128'(lat), 128'(5));
        chk("drop_out", 0, st_out_w[0], E1);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_idle", 0, 128'(busy_w[0]), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
